// File: rtl/demux_bus_16_buffered_pkg.sv
// Shared constants and helpers for the buffered 1-to-16 bus demultiplexer.
package demux_bus_16_buffered_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 5;

  // LSB of channel k within the flattened DemuxOut bus.
  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding slot: one data word plus its valid bit, with
// refill-while-draining and clear-on-drain behaviour.
module demux_slot #(
  parameter int NrOfBits = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Load,
  input  logic [NrOfBits-1:0] DataIn,
  input  logic                Ready,
  output logic                Valid,
  output logic [NrOfBits-1:0] DataOut
);

  logic                valid_d, valid_q;
  logic [NrOfBits-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (Load) begin
      // Load wins over a simultaneous drain so a refill has no bubble.
      valid_d = 1'b1;
      data_d  = DataIn;
    end else if (valid_q && Ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign Valid   = valid_q;
  assign DataOut = valid_q ? data_q : '0;

endmodule

// File: rtl/demux_bus_16_buffered.sv
// Registered 1-to-16 bus demultiplexer with per-channel valid/ready
// handshake and a registered count of full slots.
module demux_bus_16_buffered
  import demux_bus_16_buffered_pkg::*;
#(
  parameter int NrOfBits = 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Enable,
  input  logic [NrOfBits-1:0]          DemuxIn,
  input  logic [SEL_W-1:0]             Sel,
  input  logic                         InValid,
  output logic                         InReady,
  output logic [NUM_CH*NrOfBits-1:0]   DemuxOut,
  output logic [NUM_CH-1:0]            OutValid,
  input  logic [NUM_CH-1:0]            OutReady,
  output logic [CNT_W-1:0]             Occupancy
);

  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] valid_next;
  logic [CNT_W-1:0]  occupancy_d, occupancy_q;

  always_comb begin
    InReady = ~Reset & Enable & (~OutValid[Sel] | OutReady[Sel]);
    accept  = InValid & InReady;
  end

  // Occupancy is the popcount of the slots' next-state valid bits, so it
  // tracks OutValid exactly without a separate up/down counter.
  always_comb begin
    load        = '0;
    valid_next  = '0;
    occupancy_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      load[k]       = accept && (Sel == SEL_W'(k));
      valid_next[k] = load[k] | (OutValid[k] & ~OutReady[k]);
      occupancy_d   = occupancy_d + CNT_W'(valid_next[k]);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign Occupancy = occupancy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .NrOfBits(NrOfBits)
    ) u_slot (
      .Clock  (Clock),
      .Reset  (Reset),
      .Load   (load[g]),
      .DataIn (DemuxIn),
      .Ready  (OutReady[g]),
      .Valid  (OutValid[g]),
      .DataOut(DemuxOut[ch_lsb(g, NrOfBits) +: NrOfBits])
    );
  end

endmodule
